// File: rtl/exprom_loader_pkg.sv
// Shared definitions for the expansion-ROM image loader: ROM geometry,
// option-ROM signature bytes, block size and FSM state encoding.
package exprom_loader_pkg;

  localparam int ROM_AW_DEF = 9;            // 512 words = 2048 bytes
  localparam logic [7:0] SIG0 = 8'h55;      // option-ROM signature, byte 0
  localparam logic [7:0] SIG1 = 8'hAA;      // option-ROM signature, byte 1
  localparam int BLK_BYTES = 512;           // image length unit
  localparam int BLK_SHIFT = 9;             // log2(BLK_BYTES)

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_BODY,
    S_FIN
  } state_t;

endpackage

// File: rtl/exprom_pack.sv
// Byte-to-word packer and ROM write-port generator. Bytes fill lanes 0..3
// of a 32-bit word; once a word is complete it is written on the following
// cycle and the word address then advances (wrapping at 2^ROM_AW).
module exprom_pack
  import exprom_loader_pkg::*;
#(
  parameter int ROM_AW = ROM_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic [7:0]        i_byte,
  input  logic              i_valid,
  input  logic              i_last,
  output logic [31:0]       o_dinp,
  output logic              o_wren,
  output logic [ROM_AW-1:0] o_address
);

  logic [1:0]        r_lane;
  logic [31:0]       r_dinp;
  logic              r_wren;
  logic [ROM_AW-1:0] r_addr;

  // Lane fill, one-cycle write strobe, post-write address increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lane <= 2'd0;
      r_dinp <= 32'd0;
      r_wren <= 1'b0;
      r_addr <= '0;
    end else begin
      r_wren <= 1'b0;
      if (r_wren) r_addr <= r_addr + 1'b1;
      if (i_clr) begin
        r_lane <= 2'd0;
        r_dinp <= 32'd0;
        r_addr <= '0;
      end else if (i_valid) begin
        // The lane being overwritten here belongs to the next word, so a
        // strobe issued this cycle still sees the completed word.
        r_dinp[{r_lane, 3'b000} +: 8] <= i_byte;
        r_lane <= i_last ? 2'd0 : r_lane + 1'b1;
        if ((r_lane == 2'd3) || i_last) r_wren <= 1'b1;
      end
    end
  end

  assign o_dinp    = r_dinp;
  assign o_wren    = r_wren;
  assign o_address = r_addr;

endmodule

// File: rtl/exprom_loader.sv
// Expansion-ROM image loader: accepts an option-ROM image as a byte stream,
// checks signature / length / checksum, and writes packed words to the ROM.
// Optional build macro EXPROM_CSUM_FIX_EN: the last image byte is replaced
// on the fly so that the 8-bit image sum becomes zero.
module exprom_loader
  import exprom_loader_pkg::*;
#(
  parameter int ROM_AW = ROM_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [31:0]       rom_dinp,
  output logic              rom_wren,
  output logic [ROM_AW-1:0] rom_address,
  output logic              rom_enable,
  output logic              busy,
  output logic              done,
  output logic              sig_err,
  output logic              len_err,
  output logic              csum_err,
  output logic              img_ok
);

  localparam int MAX_BLK = 2 ** (ROM_AW - 7);
  localparam int CW      = ROM_AW + 3;      // byte counter reaches 4*2^ROM_AW

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, r_len;
  logic [7:0]    r_sum;
  logic          r_sig_err, r_len_err, r_csum_err, r_img_ok;

  logic          w_rdy, w_acc, w_clr, w_last, w_len_bad;
  logic [7:0]    w_byte, w_sum_nxt;

  assign w_rdy     = (r_state == S_HDR) || (r_state == S_BODY);
  assign w_acc     = s_valid & w_rdy;
  assign w_clr     = (r_state == S_IDLE) & start;
  assign w_last    = (r_state == S_BODY) && (r_cnt == r_len - 1'b1);
  assign w_len_bad = (s_data == 8'd0) || ({24'd0, s_data} > 32'(MAX_BLK));

`ifdef EXPROM_CSUM_FIX_EN
  assign w_byte = w_last ? (8'h00 - r_sum) : s_data;
`else
  assign w_byte = s_data;
`endif
  assign w_sum_nxt = r_sum + w_byte;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: signature is judged once both bytes are in, length at byte 2
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_HDR;
      S_HDR: begin
        if (w_acc) begin
          if ((r_cnt == CW'(1)) && (r_sig_err || (s_data != SIG1)))
            w_state_nxt = S_FIN;
          else if (r_cnt == CW'(2))
            w_state_nxt = w_len_bad ? S_FIN : S_BODY;
        end
      end
      S_BODY: if (w_acc && w_last) w_state_nxt = S_FIN;
      S_FIN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Byte counter, running checksum, image length and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_len      <= '0;
      r_sum      <= 8'd0;
      r_sig_err  <= 1'b0;
      r_len_err  <= 1'b0;
      r_csum_err <= 1'b0;
      r_img_ok   <= 1'b0;
    end else if (w_clr) begin
      r_cnt      <= '0;
      r_len      <= '0;
      r_sum      <= 8'd0;
      r_sig_err  <= 1'b0;
      r_len_err  <= 1'b0;
      r_csum_err <= 1'b0;
      r_img_ok   <= 1'b0;
    end else if (w_acc) begin
      r_cnt <= r_cnt + 1'b1;
      r_sum <= w_sum_nxt;
      if (r_state == S_HDR) begin
        if ((r_cnt == CW'(0)) && (s_data != SIG0)) r_sig_err <= 1'b1;
        if ((r_cnt == CW'(1)) && (s_data != SIG1)) r_sig_err <= 1'b1;
        if (r_cnt == CW'(2)) begin
          if (w_len_bad) r_len_err <= 1'b1;
          else           r_len     <= CW'(s_data) << BLK_SHIFT;
        end
      end
      // Flags settle on entry to FIN so they are valid alongside done
      if (w_last) begin
        r_csum_err <= (w_sum_nxt != 8'd0);
        r_img_ok   <= (w_sum_nxt == 8'd0);
      end
    end
  end

  exprom_pack #(.ROM_AW(ROM_AW)) u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_byte    (w_byte),
    .i_valid   (w_acc),
    .i_last    (w_acc & w_last),
    .o_dinp    (rom_dinp),
    .o_wren    (rom_wren),
    .o_address (rom_address)
  );

  assign rom_enable = rom_wren;
  assign s_ready    = w_rdy;
  assign busy       = w_rdy;
  assign done       = (r_state == S_FIN);
  assign sig_err    = r_sig_err;
  assign len_err    = r_len_err;
  assign csum_err   = r_csum_err;
  assign img_ok     = r_img_ok;

endmodule
